// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// active-low glyph table, all-off patterns and the per-slot state encoding.
package ssd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = GLYPH[hex];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking,
// frame-synchronous double-buffered value updates and leading-zero blanking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [3:0]  anodes,
  output logic [6:0]  cathodes,
  output logic        dp_n
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  slot_state_e state_q, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    idx, idx_d;

  logic [15:0] shadow, staging;
  logic [3:0]  shadow_dp, staging_dp;
  logic        pending;

  logic        wrap, boundary;
  logic [3:0]  nibble;
  logic [6:0]  glyph_c;
  logic [3:0]  lead_blank;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dpn_d;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (idx == 2'd3);
  assign nibble   = shadow[{idx, 2'b00} +: 4];

  // Digit k is a leading zero when it and every higher nibble are zero.
  assign lead_blank[3] = (shadow[15:12] == 4'h0);
  assign lead_blank[2] = lead_blank[3] && (shadow[11:8] == 4'h0);
  assign lead_blank[1] = lead_blank[2] && (shadow[7:4] == 4'h0);
  assign lead_blank[0] = 1'b0;

  ssd_hex_decoder u_dec (
    .hex   (nibble),
    .seg_c (glyph_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BLANK;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
    end
  end

  // Slot sequencing and the pin values for the current slot position.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt + CW'(1);
    idx_d   = idx;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dpn_d   = 1'b1;

    if (wrap) begin
      cnt_d   = '0;
      idx_d   = idx + 2'd1;
      state_d = S_BLANK;
    end else if (cnt_d == CNT_BLANK) begin
      state_d = S_SHOW;
    end

    case (state_q)
      S_SHOW: begin
        an_d  = ~(4'b0001 << idx);
        seg_d = (lzb_en && lead_blank[idx]) ? SEG_OFF : glyph_c;
        dpn_d = ~shadow_dp[idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anodes     <= AN_OFF;
      cathodes   <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      anodes     <= an_d;
      cathodes   <= seg_d;
      dp_n       <= dpn_d;
      frame_tick <= boundary;
      load_ack   <= boundary && (load || pending);
    end
  end

  // A load in the boundary cycle bypasses staging so it lands this frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging    <= '0;
      staging_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        staging    <= value;
        staging_dp <= dp_in;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          shadow    <= value;
          shadow_dp <= dp_in;
        end else if (pending) begin
          shadow    <= staging;
          shadow_dp <= staging_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIV=8, BLANK=2 (32-cycle frames).
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic        load;
  logic        load_ack;
  logic        frame_tick;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;
  logic        dp_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .lzb_en     (lzb_en),
    .load       (load),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .anodes     (anodes),
    .cathodes   (cathodes),
    .dp_n       (dp_n)
  );

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lzb;
    logic [27:0] cath;  // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpn;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_off(input string name);
    chk(name, {2'b00, anodes, cathodes, dp_n, frame_tick, load_ack},
        {2'b00, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
  endtask

  // Samples one full frame starting at slot 0, position 0.
  task automatic frame_check(input string tag, input logic [27:0] cath, input logic [3:0] dpn);
    for (int j = 0; j < 32; j++) begin
      int slot;
      int pos;
      logic [3:0] ea;
      logic [6:0] ec;
      logic       ed;
      slot = j / 8;
      pos  = j % 8;
      @(negedge clk);
      if (pos < 2) begin
        ea = 4'hF; ec = 7'h7F; ed = 1'b1;
      end else begin
        ea = ~(4'b0001 << slot);
        ec = cath[7*slot +: 7];
        ed = dpn[slot];
      end
      chk($sformatf("%s_cyc%0d", tag, j),
          {2'b00, anodes, cathodes, dp_n, frame_tick, load_ack},
          {2'b00, ea, ec, ed, (j == 31), 1'b0});
    end
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_ack && n < 80);
    chk({tag, "_ack_tick"}, {14'd0, load_ack, frame_tick}, 16'h0003);
  endtask

  initial begin
    vecs[0] = '{16'h0045, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h19, 7'h12}, 4'b1111};
    vecs[1] = '{16'h0045, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h12}, 4'b1011};
    vecs[2] = '{16'h0000, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
    vecs[3] = '{16'hF0A1, 4'b1111, 1'b1, {7'h0E, 7'h40, 7'h08, 7'h79}, 4'b0000};
    vecs[4] = '{16'h0300, 4'b0000, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b1111};
    vecs[5] = '{16'h96E2, 4'b1010, 1'b0, {7'h10, 7'h02, 7'h06, 7'h24}, 4'b0101};
    vecs[6] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[7] = '{16'hCD3B, 4'b0000, 1'b0, {7'h46, 7'h21, 7'h30, 7'h03}, 4'b1111};

    rst = 1'b1; value = '0; dp_in = '0; lzb_en = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    chk_off("reset_hold");

    // Release: blank/digit0 pattern with shadow=0 shows 0 everywhere.
    rst = 1'b0;
    frame_check("release", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    foreach (vecs[i]) begin
      lzb_en = vecs[i].lzb;
      repeat (3) @(negedge clk);
      load_pulse(vecs[i].value, vecs[i].dp);
      wait_ack($sformatf("vec%0d", i));
      frame_check($sformatf("vec%0d", i), vecs[i].cath, vecs[i].dpn);
    end

    // Two loads in one frame: only the later one is shown, one ack.
    lzb_en = 1'b0;
    repeat (2) @(negedge clk);
    load_pulse(16'h1111, 4'b0000);
    repeat (5) @(negedge clk);
    load_pulse(16'h8888, 4'b0000);
    wait_ack("double");
    frame_check("double", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111);

    // Load exactly in the boundary cycle (state position 31).
    repeat (31) @(negedge clk);
    value = 16'h5A5A; dp_in = 4'b1000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("boundary_load_ack", {14'd0, load_ack, frame_tick}, 16'h0003);
    frame_check("boundary", {7'h12, 7'h08, 7'h12, 7'h08}, 4'b0111);

    // Reset mid-SHOW with a load pending.
    load_pulse(16'h1234, 4'b1111);
    repeat (4) @(negedge clk);
    chk("pre_reset_show", {12'd0, anodes}, 16'h000E);
    #2 rst = 1'b1;
    #1 chk_off("reset_async");
    repeat (2) @(negedge clk);
    chk_off("reset_held");
    rst = 1'b0;
    frame_check("post_reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    frame_check("post_reset2", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter DIV, default 100000: clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK, default 2000: blanking cycles at the start of each slot, anti-ghosting; legal range 1..DIV-2.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 value  input  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 dp_in  input  4  decimal-point enable per digit; bit i belongs to digit i.
REQ-007 lzb_en  input  1  leading-zero blanking enable; level, sampled every cycle.
REQ-008 load  input  1  single-cycle strobe requesting display of value/dp_in.
REQ-009 load_ack  output  1  one-cycle pulse when a requested value becomes visible.
REQ-010 frame_tick  output  1  one-cycle pulse on the last cycle of every 4-slot frame.
REQ-011 anodes  output  4  digit enables, active-low; bit i drives digit i.
REQ-012 cathodes  output  7  segments, active-low; order {g,f,e,d,c,b,a}, bit 6 is g.
REQ-013 dp_n  output  1  decimal point, active-low.

Function
REQ-014 The slot counter cnt SHALL count 0..DIV-1 and wrap to 0; digit index idx SHALL increment mod 4 on each wrap.
REQ-015 Per-slot states: BLANK while cnt<BLANK, SHOW while cnt>=BLANK; transitions occur only at cnt==BLANK and at wrap.
REQ-016 In BLANK: anodes=4'hF, cathodes=7'h7F, dp_n=1.
REQ-017 In SHOW: anodes has only bit idx low; cathodes hold the hex decode of shadow nibble idx; dp_n = ~shadow_dp[idx].
REQ-018 All outputs SHALL be registered: the pins show the state of cnt/idx from the previous cycle (one-cycle latency).
REQ-019 Hex decode, active-low: 0=7'h40, 1=7'h79, 4=7'h19, 5=7'h12, 8=7'h00, F=7'h0E; the remaining digits follow the standard 7-segment glyphs.
REQ-020 Frame boundary: the cycle in which idx==3 and cnt==DIV-1; frame_tick SHALL be high on the output during the cycle after that state.
REQ-021 load SHALL copy value/dp_in into a staging register and set pending; if load is asserted again before the transfer, the later value replaces the earlier one.
REQ-022 At the frame boundary, if pending is set, staging SHALL be copied to shadow and pending cleared; load_ack SHALL pulse on the following cycle, aligned with frame_tick.
REQ-023 If load occurs in the boundary cycle itself, that value SHALL be transferred at that boundary; there is no one-frame delay.
REQ-024 The displayed digits SHALL change only at frame boundaries; there is no tearing mid-frame.
REQ-025 Leading-zero blanking (lzb_en=1): digit k, k in 1..3, SHALL be blanked when shadow nibbles k..3 are all zero; digit 0 is never blanked.
REQ-026 A blanked digit keeps its anode asserted in SHOW, drives cathodes=7'h7F, and still honours its dp bit.

Reset
REQ-027 While rst is high, regardless of clk: cnt=0, idx=0, shadow=0, shadow_dp=0, staging=0, pending=0, anodes=4'hF, cathodes=7'h7F, dp_n=1, load_ack=0, frame_tick=0.
REQ-028 A load that is pending when reset asserts SHALL be discarded; scanning restarts at digit 0, in BLANK, on the first edge after rst deasserts.

Structure
REQ-029 Package ssd_pkg SHALL hold the digit count (4), the 16-entry active-low glyph table, and the all-off constants (7'h7F, 4'hF).
REQ-030 The hex decode SHALL be a sub-module ssd_hex_decoder (4-bit in, 7-bit active-low out), purely combinational.
REQ-031 The cnt width SHALL be $clog2(DIV); no other dividers are permitted.

Verification (DIV=8, BLANK=2)
REQ-032 Reset release -> anodes 4'hF for 2 cycles, then 4'hE for 6 cycles, then 4'hF for 2 cycles, then 4'hD; cathodes=7'h40 in every SHOW slot.
REQ-033 load with value=16'h0045, lzb_en=0 at cycle 3 -> shadow unchanged until the first boundary; load_ack and frame_tick high together at output cycle 33; the next frame shows digit0=7'h12, digit1=7'h19, digit2=7'h40, digit3=7'h40.
REQ-034 Same value with lzb_en=1, dp_in=4'b0100 -> digits 2 and 3 show cathodes=7'h7F; digit 2 shows dp_n=0; digits 0 and 1 are unchanged.
REQ-035 load 16'h1111 then load 16'h8888 within one frame -> a single load_ack; every digit shows 7'h00; 16'h1111 is never displayed.
REQ-036 load asserted exactly in the boundary cycle -> transferred at that boundary, with load_ack on the next cycle.
REQ-037 rst pulsed mid-SHOW with a load pending -> outputs all-off within the same cycle; no load_ack; the display restarts at digit 0 with shadow=0.
